sram_march_bist: RTL and testbench
==================================

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM address width; test range is 0 to 2^ADDR_W-1.
REQ-002 Parameter DATA_W, default 8, SRAM data width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a test; sampled only in IDLE.
REQ-006 busy  output  1  high while the test sequence runs.
REQ-007 done  output  1  high from test completion until the next accepted start.
REQ-008 pass  output  1  result, valid while done=1; 1 means no miscompare.
REQ-009 mem_we  output  1  SRAM write enable: 1 writes, 0 reads.
REQ-010 mem_addr  output  ADDR_W  SRAM address.
REQ-011 mem_wdata  output  DATA_W  SRAM write data.
REQ-012 mem_rdata  input  DATA_W  SRAM registered read data, valid one cycle after a read cycle, unchanged by write cycles.
REQ-013 fail_addr  output  ADDR_W  address of the first miscompare.
REQ-014 fail_exp, fail_act  output  DATA_W each  expected and actual data of the first miscompare.
REQ-015 err_cnt  output  16  miscompare count, saturating at 0xFFFF.

Function
REQ-016 FSM states: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
- IDLE->M0 on start.
- Mk->Mk+1 after the last address of element k.
- M5->DRAIN->DONE.
- DONE->M0 on start.
REQ-017 March C- sequence, Z=all-zeros, O=all-ones:
- M0 up: w Z.
- M1 up: r Z, w O.
- M2 up: r O, w Z.
- M3 down: r Z, w O.
- M4 down: r O, w Z.
- M5 down: r Z.
REQ-018 Addressing: up runs 0 to max, down runs max to 0; the counter wraps to the start value of the next element.
REQ-019 Read/write elements use two cycles per address: read cycle (mem_we=0), then write cycle (mem_we=1) at the same address.
REQ-020 mem_rdata is compared in the cycle after each read. For M1-M4 this is the write cycle. For M5 it is the next read cycle, or DRAIN for address 0.
REQ-021 M0 and M5 take one cycle per address. busy stays high for exactly 10*2^ADDR_W+1 cycles, and done rises on the following cycle.
REQ-022 The first mem operation occurs in the cycle after start is sampled. mem_we is 0 outside M0-M4.
REQ-023 A miscompare clears pass for the rest of the test and increments err_cnt. The test always runs to completion; there is no early abort.
REQ-024 fail_* are captured on the first miscompare only and held until the next accepted start.
REQ-025 start while busy is ignored. start and rst in the same cycle: rst wins.
REQ-026 An accepted start clears done, sets pass=1, and zeroes err_cnt and fail_*.

Reset
REQ-027 rst at any time, including mid-test, forces IDLE on the next edge with: busy=0, done=0, pass=0, mem_we=0, mem_addr=0, mem_wdata=0, fail_*=0, err_cnt=0.
REQ-028 SRAM contents are not restored after reset.

Configuration
REQ-029 The macro is SRAM_BIST_ERRLOG_EN.
REQ-030 With it defined: fail_addr, fail_exp, fail_act and err_cnt are implemented per REQ-023/024.
REQ-031 Without it: those outputs are constant 0, their registers are removed, and pass/done behaviour is unchanged.

Structure
REQ-032 Package sram_bist_pkg holds:
- the FSM state enum;
- element descriptors (direction, read value, write value);
- constants PAT_Z and PAT_O.
REQ-033 One sub-module, sram_bist_addr_gen: loadable up/down address counter with a last-address flag.

Verification (ADDR_W=4, DATA_W=8, behavioural SRAM model with 1-cycle registered read)
REQ-034 Fault-free SRAM, start pulse -> busy high 161 cycles, then done=1, pass=1, err_cnt=0.
REQ-035 Bit 0 of address 5 stuck at 1 -> pass=0, fail_addr=5, fail_exp=0x00, fail_act=0x01, err_cnt=3.
REQ-036 Bit 7 of address 15 stuck at 0 -> pass=0, fail_addr=15, fail_exp=0xFF, fail_act=0x7F, err_cnt=2.
REQ-037 rst asserted at cycle 40 of a test -> next cycle IDLE, all outputs 0. A new start then gives a clean 161-cycle pass.
REQ-038 start re-pulsed at cycle 20 of a test -> ignored, total busy still 161. start in DONE -> done drops and a new test runs.
REQ-039 Build without SRAM_BIST_ERRLOG_EN, fault as in REQ-035 -> pass=0, fail_* and err_cnt stay 0.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types for the March C- SRAM BIST: FSM state encoding, element descriptors
// and the two data backgrounds (stored as one-bit codes, replicated to the data width).
package sram_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1    = 4'd2,
        ST_M2    = 4'd3,
        ST_M3    = 4'd4,
        ST_M4    = 4'd5,
        ST_M5    = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    localparam logic PAT_Z    = 1'b0;
    localparam logic PAT_O    = 1'b1;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef struct packed {
        logic down;
        logic rd;
        logic wr;
        logic rval;
        logic wval;
    } elem_t;

    // Non-march states return an all-zero descriptor: no read, no write.
    function automatic elem_t elem_desc(input state_t s);
        elem_t d;
        d = '0;
        case (s)
            ST_M0:   d = '{down: DIR_UP,   rd: 1'b0, wr: 1'b1, rval: PAT_Z, wval: PAT_Z};
            ST_M1:   d = '{down: DIR_UP,   rd: 1'b1, wr: 1'b1, rval: PAT_Z, wval: PAT_O};
            ST_M2:   d = '{down: DIR_UP,   rd: 1'b1, wr: 1'b1, rval: PAT_O, wval: PAT_Z};
            ST_M3:   d = '{down: DIR_DOWN, rd: 1'b1, wr: 1'b1, rval: PAT_Z, wval: PAT_O};
            ST_M4:   d = '{down: DIR_DOWN, rd: 1'b1, wr: 1'b1, rval: PAT_O, wval: PAT_Z};
            ST_M5:   d = '{down: DIR_DOWN, rd: 1'b1, wr: 1'b0, rval: PAT_Z, wval: PAT_Z};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter for the march elements; 'last' flags the final
// address in the current direction.
module sram_bist_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] addr_r;

    // Counter register: load takes priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= '0;
        end else if (load) begin
            addr_r <= load_val;
        end else if (step) begin
            addr_r <= down ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr = addr_r;
    assign last = down ? (addr_r == '0) : (addr_r == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for a single-port SRAM with one-cycle registered read data.
// Optional error log (fail_addr/fail_exp/fail_act/err_cnt) enabled by SRAM_BIST_ERRLOG_EN.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [15:0]       err_cnt
);

    state_t            state_r, state_nxt;
    logic              phase_r, phase_nxt;
    logic              ld, stp;
    logic [ADDR_W-1:0] ld_val;
    logic [ADDR_W-1:0] addr;
    logic              addr_last;
    logic              start_acc, is_rd, miscmp;
    logic              busy_r, done_r, pass_r, mem_we_r, rd_pend_r;
    logic              we_nxt, busy_nxt;
    logic [DATA_W-1:0] mem_wdata_r, wdata_nxt, exp_r;

    sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .step     (stp),
        .down     (elem_desc(state_r).down),
        .addr     (addr),
        .last     (addr_last)
    );

    assign start_acc = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    // phase_r selects the write half of a read/write element.
    assign is_rd  = elem_desc(state_r).rd && !(elem_desc(state_r).wr && phase_r);
    assign miscmp = rd_pend_r && (mem_rdata != exp_r);

    // Next-state, phase and address-counter control.
    always_comb begin
        state_nxt = state_r;
        phase_nxt = 1'b0;
        ld        = 1'b0;
        stp       = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_M0;
                    ld        = 1'b1;
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_M0, ST_M5: begin
                if (addr_last) begin
                    state_nxt = state_t'(state_r + 4'd1);
                    ld        = 1'b1;
                end else begin
                    stp = 1'b1;
                end
            end
            ST_M1, ST_M2, ST_M3, ST_M4: begin
                if (!phase_r) begin
                    phase_nxt = 1'b1;
                end else if (addr_last) begin
                    state_nxt = state_t'(state_r + 4'd1);
                    ld        = 1'b1;
                end else begin
                    stp = 1'b1;
                end
            end
            ST_DRAIN: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign ld_val    = elem_desc(state_nxt).down ? '1 : '0;
    assign we_nxt    = elem_desc(state_nxt).wr && !(elem_desc(state_nxt).rd && !phase_nxt);
    assign wdata_nxt = we_nxt ? {DATA_W{elem_desc(state_nxt).wval}} : '0;
    assign busy_nxt  = !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE));

    // Control state, registered outputs and the pending-read compare pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            phase_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
            rd_pend_r   <= 1'b0;
            exp_r       <= '0;
        end else begin
            state_r     <= state_nxt;
            phase_r     <= phase_nxt;
            busy_r      <= busy_nxt;
            done_r      <= (state_nxt == ST_DONE);
            mem_we_r    <= we_nxt;
            mem_wdata_r <= wdata_nxt;
            rd_pend_r   <= is_rd;
            exp_r       <= {DATA_W{elem_desc(state_r).rval}};
            if (start_acc) begin
                pass_r <= 1'b1;
            end else if (miscmp) begin
                pass_r <= 1'b0;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr;
    assign mem_wdata = mem_wdata_r;

`ifdef SRAM_BIST_ERRLOG_EN
    logic [ADDR_W-1:0] rd_addr_r, fail_addr_r;
    logic [DATA_W-1:0] fail_exp_r, fail_act_r;
    logic [15:0]       err_cnt_r;

    // Error log: first miscompare is latched, count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_r   <= '0;
            fail_addr_r <= '0;
            fail_exp_r  <= '0;
            fail_act_r  <= '0;
            err_cnt_r   <= 16'h0000;
        end else begin
            rd_addr_r <= addr;
            if (start_acc) begin
                fail_addr_r <= '0;
                fail_exp_r  <= '0;
                fail_act_r  <= '0;
                err_cnt_r   <= 16'h0000;
            end else if (miscmp) begin
                if (err_cnt_r == 16'h0000) begin
                    fail_addr_r <= rd_addr_r;
                    fail_exp_r  <= exp_r;
                    fail_act_r  <= mem_rdata;
                end
                if (err_cnt_r != 16'hFFFF) begin
                    err_cnt_r <= err_cnt_r + 16'h0001;
                end
            end
        end
    end

    assign fail_addr = fail_addr_r;
    assign fail_exp  = fail_exp_r;
    assign fail_act  = fail_act_r;
    assign err_cnt   = err_cnt_r;
`else
    assign fail_addr = '0;
    assign fail_exp  = '0;
    assign fail_act  = '0;
    assign err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist (ADDR_W=4): SRAM model with injectable stuck-at fault and an
// algorithmic March C- reference producing the expected op trace and error log.
module tb_sram_march_bist;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
    localparam int BUSY_CYCLES = 10 * N + 1;

    logic          clk = 1'b0;
    logic          rst, start;
    logic          busy, done, pass, mem_we;
    logic [AW-1:0] mem_addr, fail_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, fail_exp, fail_act;
    logic [15:0]   err_cnt;

    int checks   = 0;
    int failures = 0;

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // SRAM with one stuck-at bit applied on the read path.
    logic [DW-1:0] sram [N];
    logic          flt_en = 1'b0;
    logic [AW-1:0] flt_addr = '0;
    int            flt_bit = 0;
    logic          flt_val = 1'b0;

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (flt_en && a == flt_addr) r[flt_bit] = flt_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        else        mem_rdata      <= faulty(mem_addr, sram[mem_addr]);
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;
    op_t ops[$];

    logic          m_pass;
    int            m_err;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_fexp, m_fact;

    // March C- as a table: direction, read background (-1 none), write background (-1 none).
    task automatic build_model();
        int e_dn[6] = '{0, 0, 0, 1, 1, 1};
        int e_rd[6] = '{-1, 0, 1, 0, 1, 0};
        int e_wr[6] = '{0, 1, 0, 1, 0, -1};
        logic [DW-1:0] mm [N];
        logic [DW-1:0] v, ex, w;
        logic [AW-1:0] a;
        int err = 0;
        ops.delete();
        m_faddr = '0; m_fexp = '0; m_fact = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = AW'(e_dn[e] != 0 ? N - 1 - i : i);
                if (e_rd[e] >= 0) begin
                    ex = (e_rd[e] == 1) ? 8'hFF : 8'h00;
                    v  = faulty(a, mm[a]);
                    ops.push_back('{1'b0, a, 8'h00});
                    if (v !== ex) begin
                        if (err == 0) begin m_faddr = a; m_fexp = ex; m_fact = v; end
                        err++;
                    end
                end
                if (e_wr[e] >= 0) begin
                    w = (e_wr[e] == 1) ? 8'hFF : 8'h00;
                    mm[a] = w;
                    ops.push_back('{1'b1, a, w});
                end
            end
        end
        m_err  = (err > 65535) ? 65535 : err;
        m_pass = (err == 0);
`ifndef SRAM_BIST_ERRLOG_EN
        m_faddr = '0; m_fexp = '0; m_fact = '0; m_err = 0;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".pass"}, 32'(pass), 32'd0);
        chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, ".fail_addr"}, 32'(fail_addr), 32'd0);
        chk({tag, ".fail_exp"}, 32'(fail_exp), 32'd0);
        chk({tag, ".fail_act"}, 32'(fail_act), 32'd0);
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // One full test; optional start re-pulse or reset abort at a given busy cycle.
    task automatic run_test(input string tag, input int repulse_at, input int rst_at);
        int  cyc = 0;
        int  trace_err = 0;
        op_t op;
        build_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".start_busy"}, 32'(busy), 32'd1);
        chk({tag, ".start_done"}, 32'(done), 32'd0);
        while (busy === 1'b1 && cyc < 4 * BUSY_CYCLES) begin
            if (ops.size() > 0) begin
                op = ops.pop_front();
                if (mem_we !== op.we || mem_addr !== op.addr || (op.we && mem_wdata !== op.wdata))
                    trace_err++;
            end else if (mem_we !== 1'b0) begin
                trace_err++;
            end
            cyc++;
            if (cyc == repulse_at) start = 1'b1;
            if (cyc == rst_at) rst = 1'b1;
            tick();
            start = 1'b0;
            if (cyc == rst_at) begin
                rst = 1'b0;
                check_zero({tag, ".abort"});
                return;
            end
        end
        chk({tag, ".busy_cycles"}, 32'(cyc), 32'(BUSY_CYCLES));
        chk({tag, ".trace"}, 32'(trace_err + ops.size()), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".pass"}, 32'(pass), 32'(m_pass));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
        chk({tag, ".fail_addr"}, 32'(fail_addr), 32'(m_faddr));
        chk({tag, ".fail_exp"}, 32'(fail_exp), 32'(m_fexp));
        chk({tag, ".fail_act"}, 32'(fail_act), 32'(m_fact));
        tick();
        chk({tag, ".done_hold"}, 32'(done), 32'd1);
        chk({tag, ".idle_we"}, 32'(mem_we), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_zero("reset");

        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_zero("rst_wins");

        flt_en = 1'b0;
        run_test("clean", 0, 0);
        chk("clean.pass_const", 32'(pass), 32'd1);

        flt_en = 1'b1; flt_addr = 4'd5; flt_bit = 0; flt_val = 1'b1;
        run_test("sa1_a5_b0", 0, 0);
        chk("sa1_a5_b0.pass_const", 32'(pass), 32'd0);
`ifdef SRAM_BIST_ERRLOG_EN
        chk("sa1_a5_b0.err_const", 32'(err_cnt), 32'd3);
        chk("sa1_a5_b0.faddr_const", 32'(fail_addr), 32'd5);
        chk("sa1_a5_b0.fact_const", 32'(fail_act), 32'h01);
`else
        chk("sa1_a5_b0.err_off", 32'(err_cnt), 32'd0);
`endif

        flt_addr = 4'd15; flt_bit = 7; flt_val = 1'b0;
        run_test("sa0_a15_b7", 0, 0);
        chk("sa0_a15_b7.pass_const", 32'(pass), 32'd0);
`ifdef SRAM_BIST_ERRLOG_EN
        chk("sa0_a15_b7.err_const", 32'(err_cnt), 32'd2);
        chk("sa0_a15_b7.fexp_const", 32'(fail_exp), 32'hFF);
        chk("sa0_a15_b7.fact_const", 32'(fail_act), 32'h7F);
`endif

        for (int k = 0; k < 6; k++) begin
            flt_en   = ($urandom_range(0, 3) != 0);
            flt_addr = AW'($urandom_range(0, N - 1));
            flt_bit  = $urandom_range(0, DW - 1);
            flt_val  = 1'($urandom_range(0, 1));
            run_test($sformatf("rand%0d", k), 0, 0);
        end

        flt_en = 1'b0;
        run_test("repulse", 20, 0);
        run_test("abort", 0, 40);
        run_test("after_abort", 0, 0);
        chk("after_abort.pass_const", 32'(pass), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
